// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Shared definitions for the seven-segment display path. It holds
//            the legal segment patterns {a,b,c,d,e,f,g} (the encoder uses the
//            same table), the scan-decoder FSM state type and the nibble value
//            reported for an illegal pattern.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment patterns ordered {a,b,c,d,e,f,g}, where 1 = lit.
    localparam logic [6:0] c_seg_0 = 7'b1111110;
    localparam logic [6:0] c_seg_1 = 7'b0110000;
    localparam logic [6:0] c_seg_2 = 7'b1101101;
    localparam logic [6:0] c_seg_3 = 7'b1111001;
    localparam logic [6:0] c_seg_4 = 7'b0110011;
    localparam logic [6:0] c_seg_5 = 7'b1011011;
    localparam logic [6:0] c_seg_6 = 7'b1011111;
    localparam logic [6:0] c_seg_7 = 7'b1110000;
    localparam logic [6:0] c_seg_8 = 7'b1111111;
    localparam logic [6:0] c_seg_9 = 7'b1111011;

    // Nibble reported for any pattern outside the table above.
    localparam logic [3:0] ERR_NIBBLE = 4'hF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PUBLISH = 2'd2
    } seg7_state_e;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pattern_decode
// Purpose  : Combinational inverse of the BCD-to-7-segment encoder. It maps
//            a segment pattern back to its BCD digit and flags patterns that
//            the encoder can never produce.
// Ports    : i_seg    [6:0] segment pattern {a..g}, 1 = lit
//            o_nibble [3:0] decoded digit, ERR_NIBBLE when illegal
//            o_err          1 when the pattern is illegal
// Revision : 1.0 - initial release
// ============================================================================
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_err
);

    always_comb begin
        o_nibble = ERR_NIBBLE;
        o_err    = 1'b1;
        case (i_seg)
            c_seg_0: begin o_nibble = 4'd0; o_err = 1'b0; end
            c_seg_1: begin o_nibble = 4'd1; o_err = 1'b0; end
            c_seg_2: begin o_nibble = 4'd2; o_err = 1'b0; end
            c_seg_3: begin o_nibble = 4'd3; o_err = 1'b0; end
            c_seg_4: begin o_nibble = 4'd4; o_err = 1'b0; end
            c_seg_5: begin o_nibble = 4'd5; o_err = 1'b0; end
            c_seg_6: begin o_nibble = 4'd6; o_err = 1'b0; end
            c_seg_7: begin o_nibble = 4'd7; o_err = 1'b0; end
            c_seg_8: begin o_nibble = 4'd8; o_err = 1'b0; end
            c_seg_9: begin o_nibble = 4'd9; o_err = 1'b0; end
            default: begin o_nibble = ERR_NIBBLE; o_err = 1'b1; end
        endcase
    end

endmodule : seg7_pattern_decode
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Samples a multiplexed seven-segment bus with one-hot digit
//            enables, debounces each strobed digit, decodes it back to BCD and
//            publishes the complete frame with a one-cycle valid pulse.
//            Partial frames that stall are discarded after TIMEOUT cycles.
// Ports    : clk                    rising-edge clock
//            reset                  asynchronous active-high reset
//            seg       [6:0]        segment lines {a..g}, 1 = lit
//            dig_en    [DIGITS-1:0] one-hot digit enables, bit 0 = rightmost
//            bcd_out   [4*DIGITS-1:0] published frame, nibble i = position i
//            digit_err [DIGITS-1:0] illegal-pattern flags of published frame
//            frame_valid            one-cycle pulse, frame outputs updated
//            frame_timeout          one-cycle pulse, partial frame dropped
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 3,
    parameter int TIMEOUT       = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     dig_en,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_err,
    output logic                  frame_valid,
    output logic                  frame_timeout
);

    localparam int          IDLE_W        = $clog2(TIMEOUT + 1);
    localparam logic [3:0]  c_stable      = 4'(STABLE_CYCLES);
    localparam logic [3:0]  c_stable_last = 4'(STABLE_CYCLES - 1);
    localparam logic [IDLE_W-1:0] c_idle_last = IDLE_W'(TIMEOUT - 1);

    logic [DIGITS+6:0]    r_s1;
    logic [3:0]           r_cnt;
    logic [DIGITS-1:0]    r_mask;
    logic [4*DIGITS-1:0]  r_shadow;
    logic [DIGITS-1:0]    r_shadow_err;
    logic [IDLE_W-1:0]    r_idle_cnt;
    seg7_state_e          r_state;

    seg7_state_e          w_state_next;
    logic [DIGITS-1:0]    w_mask_next;
    logic [DIGITS-1:0]    w_dig;
    logic [6:0]           w_seg;
    logic                 w_sample_change;
    logic                 w_accept;
    logic                 w_capture;
    logic [DIGITS-1:0]    w_capture_mask;
    logic [3:0]           w_nibble;
    logic                 w_err;
    logic                 w_publish;
    logic                 w_timeout;

    assign w_dig = r_s1[DIGITS+6:7];
    assign w_seg = r_s1[6:0];

    // The counter reaches STABLE_CYCLES on the same edge that sees the
    // sample register unchanged while holding STABLE_CYCLES-1, so the capture
    // uses the already-stable contents of r_s1 on that edge.
    assign w_sample_change = ({dig_en, seg} != r_s1);
    assign w_accept        = !w_sample_change && (r_cnt == c_stable_last);
    assign w_capture       = w_accept && $onehot(w_dig);
    assign w_capture_mask  = w_capture ? w_dig : '0;

    seg7_pattern_decode u_decode (
        .i_seg    (w_seg),
        .o_nibble (w_nibble),
        .o_err    (w_err)
    );

    // Sample register and debounce counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1  <= '0;
            r_cnt <= 4'd0;
        end else begin
            r_s1 <= {dig_en, seg};
            if (w_sample_change) begin
                r_cnt <= 4'd1;
            end else if (r_cnt != c_stable) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Shadow frame; a repeated capture of a position simply overwrites it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shadow     <= '0;
            r_shadow_err <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (w_capture && w_dig[i]) begin
                    r_shadow[4*i +: 4] <= w_nibble;
                    r_shadow_err[i]    <= w_err;
                end
            end
        end
    end

    // Idle counter only runs while a partial frame is being collected;
    // ignored (non-one-hot) acceptances do not restart it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle_cnt <= '0;
        end else if (w_capture || (r_state != COLLECT)) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        w_publish    = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            IDLE: begin
                w_mask_next = w_capture_mask;
                if (w_capture) begin
                    w_state_next = COLLECT;
                end
            end
            COLLECT: begin
                w_mask_next = r_mask | w_capture_mask;
                if (&r_mask) begin
                    w_state_next = PUBLISH;
                    w_publish    = 1'b1;
                end else if (!w_capture && (r_idle_cnt == c_idle_last)) begin
                    w_state_next = IDLE;
                    w_mask_next  = '0;
                    w_timeout    = 1'b1;
                end
            end
            PUBLISH: begin
                // A capture landing here starts the next frame immediately.
                w_mask_next  = w_capture_mask;
                w_state_next = w_capture ? COLLECT : IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_mask_next  = '0;
            end
        endcase
    end

    // Frame outputs load on the edge that enters PUBLISH, so frame_valid is
    // high exactly during the PUBLISH cycle and bcd_out changes with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bcd_out       <= '0;
            digit_err     <= '0;
            frame_valid   <= 1'b0;
            frame_timeout <= 1'b0;
        end else begin
            frame_valid   <= w_publish;
            frame_timeout <= w_timeout;
            if (w_publish) begin
                bcd_out   <= r_shadow;
                digit_err <= r_shadow_err;
            end
        end
    end

endmodule : seg7_scan_decoder
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Purpose  : Directed self-checking bench for seg7_scan_decoder with default
//            parameters (4 digits, 3 stable cycles, 1024-cycle timeout).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_decoder;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PBAD = 7'b1001001;

    logic        clk;
    logic        reset;
    logic [6:0]  seg;
    logic [3:0]  dig_en;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        frame_timeout;

    int n_cmp = 0;
    int n_mis = 0;
    int n_fv  = 0;
    int n_ft  = 0;

    seg7_scan_decoder #(
        .DIGITS        (4),
        .STABLE_CYCLES (3),
        .TIMEOUT       (1024)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .seg           (seg),
        .dig_en        (dig_en),
        .bcd_out       (bcd_out),
        .digit_err     (digit_err),
        .frame_valid   (frame_valid),
        .frame_timeout (frame_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters: sampled at the rising edge, i.e. the value held during
    // the preceding cycle.
    always @(posedge clk) begin
        if (frame_valid === 1'b1)   n_fv <= n_fv + 1;
        if (frame_timeout === 1'b1) n_ft <= n_ft + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the next rising edge samples the new value.
    task automatic drive(input logic [3:0] en, input logic [6:0] s);
        dig_en = en;
        seg    = s;
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        seg    = 7'd0;
        dig_en = 4'd0;
        wait_n(3);
        chk("reset_bcd", 32'(bcd_out), 32'h0);
        chk("reset_err", 32'(digit_err), 32'h0);
        chk("reset_fv", 32'(frame_valid), 32'h0);
        chk("reset_ft", 32'(frame_timeout), 32'h0);
        reset = 1'b0;

        // Frame 1: digits 3..0 = 1,9,4,7
        drive(4'b1000, P1); wait_n(4);
        drive(4'b0100, P9); wait_n(4);
        drive(4'b0010, P4); wait_n(4);
        drive(4'b0001, P7); wait_n(3);
        chk("f1_fv_early", 32'(frame_valid), 32'h0);
        wait_n(1);
        chk("f1_fv", 32'(frame_valid), 32'h1);
        chk("f1_bcd", 32'(bcd_out), 32'h1947);
        chk("f1_err", 32'(digit_err), 32'h0);
        drive(4'b0000, 7'd0); wait_n(1);
        chk("f1_fv_pulse", 32'(frame_valid), 32'h0);
        wait_n(4);
        chk("f1_count", 32'(n_fv), 32'd1);

        // Frame 2: digit 1 bounces before settling on "1"
        drive(4'b1000, P8); wait_n(4);
        drive(4'b0100, P5); wait_n(4);
        drive(4'b0001, P3); wait_n(4);
        for (int t = 0; t < 5; t++) begin
            drive(4'b0010, (t % 2 == 0) ? P7 : P6);
            wait_n(2);
        end
        chk("f2_no_early", 32'(n_fv), 32'd1);
        drive(4'b0010, P1); wait_n(4);
        chk("f2_fv", 32'(frame_valid), 32'h1);
        chk("f2_bcd", 32'(bcd_out), 32'h8513);
        drive(4'b0000, 7'd0); wait_n(4);

        // Frame 3: illegal pattern on digit 2
        drive(4'b1000, P0); wait_n(4);
        drive(4'b0100, PBAD); wait_n(4);
        drive(4'b0010, P6); wait_n(4);
        drive(4'b0001, P2); wait_n(4);
        chk("f3_fv", 32'(frame_valid), 32'h1);
        chk("f3_bcd", 32'(bcd_out), 32'h0F62);
        chk("f3_err", 32'(digit_err), 32'h4);
        drive(4'b0000, 7'd0); wait_n(4);

        // Partial frame: digits 0 and 1 only, then idle until timeout
        drive(4'b0001, P3); wait_n(4);
        drive(4'b0010, P5); wait_n(4);
        drive(4'b0000, 7'd0); wait_n(1022);
        chk("to_early", 32'(frame_timeout), 32'h0);
        wait_n(1);
        chk("to_pulse", 32'(frame_timeout), 32'h1);
        wait_n(1);
        chk("to_pulse_end", 32'(frame_timeout), 32'h0);
        wait_n(70);
        chk("to_count", 32'(n_ft), 32'd1);
        chk("to_fv_count", 32'(n_fv), 32'd3);
        chk("to_bcd_kept", 32'(bcd_out), 32'h0F62);
        chk("to_err_kept", 32'(digit_err), 32'h4);

        // Multi-hot enables are ignored; then a frame of 8s
        drive(4'b0011, P8); wait_n(10);
        drive(4'b1000, P8); wait_n(4);
        drive(4'b0100, P8); wait_n(4);
        drive(4'b0010, P8); wait_n(4);
        chk("mh_no_early", 32'(n_fv), 32'd3);
        drive(4'b0001, P8); wait_n(4);
        chk("mh_fv", 32'(frame_valid), 32'h1);
        chk("mh_bcd", 32'(bcd_out), 32'h8888);
        drive(4'b0000, 7'd0); wait_n(4);

        // Reset with three of four digits captured
        drive(4'b1000, P2); wait_n(4);
        drive(4'b0100, P2); wait_n(4);
        drive(4'b0010, P2); wait_n(4);
        drive(4'b0000, 7'd0);
        reset = 1'b1;
        #1;
        chk("rst_bcd", 32'(bcd_out), 32'h0);
        chk("rst_err", 32'(digit_err), 32'h0);
        wait_n(2);
        reset = 1'b0;
        drive(4'b0001, P5); wait_n(4);
        drive(4'b0010, P9); wait_n(4);
        drive(4'b0100, P0); wait_n(4);
        chk("rst_no_stale", 32'(n_fv), 32'd4);
        drive(4'b1000, P4); wait_n(4);
        chk("rst_fv", 32'(frame_valid), 32'h1);
        chk("rst_bcd_new", 32'(bcd_out), 32'h4095);
        chk("rst_err_new", 32'(digit_err), 32'h0);
        drive(4'b0000, 7'd0); wait_n(4);
        chk("final_fv_count", 32'(n_fv), 32'd5);
        chk("final_ft_count", 32'(n_ft), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_seg7_scan_decoder
`default_nettype wire
